// File: rtl/arrow_judge_pkg.sv
// Shared definitions for the arrow judge and the score counter it feeds.
package arrow_judge_pkg;

  // Score codes consumed by the score counter.
  localparam logic [1:0] SC_NONE = 2'b00;
  localparam logic [1:0] SC_P1   = 2'b01;
  localparam logic [1:0] SC_P2   = 2'b10;
  localparam logic [1:0] SC_N2   = 2'b11;

  // Per-lane judging state.
  typedef enum logic {
    LS_IDLE = 1'b0,
    LS_WIN  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/arrow_judge_lane.sv
// One lane of the arrow judge: key edge detection, timing window FSM,
// window counter and a single-entry pending result slot.
//
// Slot handshake: slot_valid is held high with slot_code stable until the
// scheduler raises grant for one cycle; the slot is consumed on that clock
// edge. A result arriving on the same edge as a grant refills the slot with
// no loss. A result arriving while the slot is valid and not granted is
// discarded and drop pulses for that cycle.
module lane_judge
  import arrow_judge_pkg::*;
#(
  parameter int PERF_LEN = 4,
  parameter int GOOD_LEN = 8,
  parameter int CNT_W    = 4,
  parameter int PENALIZE = 1
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             arrow_in,
  input  logic             key,
  input  logic             grant,
  output logic             slot_valid,
  output logic [1:0]       slot_code,
  output logic             drop
);

  localparam logic [CNT_W-1:0] PERF_C  = CNT_W'(PERF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERF_LEN + GOOD_LEN - 1);

  lane_state_t      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             key_q;
  logic             armed;
  logic             press;
  logic             res_v;
  logic [1:0]       res_code;
  logic             slot_valid_n;
  logic [1:0]       slot_code_n;

  // A key held through reset release must not count as a press, so edges
  // are only recognised once one clock has sampled the key level.
  assign press = key & ~key_q & armed;

  // State, counter, key history and pending slot registers.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= LS_IDLE;
      cnt        <= '0;
      key_q      <= 1'b0;
      armed      <= 1'b0;
      slot_valid <= 1'b0;
      slot_code  <= SC_NONE;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      key_q      <= key;
      armed      <= 1'b1;
      slot_valid <= slot_valid_n;
      slot_code  <= slot_code_n;
    end
  end

  // Window FSM: decides the lane result for this cycle and the next window.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    res_v    = 1'b0;
    res_code = SC_NONE;
    case (state)
      LS_IDLE: begin
        if (arrow_in && press) begin
          res_v    = 1'b1;
          res_code = SC_P2;
        end else if (arrow_in) begin
          state_n = LS_WIN;
          cnt_n   = '0;
        end else if (press && (PENALIZE != 0)) begin
          res_v    = 1'b1;
          res_code = SC_N2;
        end
      end
      LS_WIN: begin
        if (press) begin
          res_v    = 1'b1;
          res_code = (cnt < PERF_C) ? SC_P2 : SC_P1;
          state_n  = arrow_in ? LS_WIN : LS_IDLE;
          cnt_n    = '0;
        end else if (arrow_in) begin
          // New arrow closes the unanswered window as a miss.
          res_v    = 1'b1;
          res_code = SC_N2;
          state_n  = LS_WIN;
          cnt_n    = '0;
        end else if (cnt == CNT_MAX) begin
          res_v    = 1'b1;
          res_code = SC_N2;
          state_n  = LS_IDLE;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = LS_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pending slot: a grant frees the slot before a new result is stored.
  always_comb begin
    drop         = 1'b0;
    slot_valid_n = slot_valid & ~grant;
    slot_code_n  = slot_code;
    if (res_v) begin
      if (slot_valid_n) begin
        drop = 1'b1;
      end else begin
        slot_valid_n = 1'b1;
        slot_code_n  = res_code;
      end
    end
  end

endmodule

// File: rtl/arrow_judge.sv
// Arrow judge top: per-lane judges plus a round-robin output scheduler that
// inserts a 00 cycle after every code so the score counter can carry.
module arrow_judge
  import arrow_judge_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int PERF_LEN = 4,
  parameter int GOOD_LEN = 8,
  parameter int CNT_W    = 4,
  parameter int PENALIZE = 1
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic [LANES-1:0] arrow_in,
  input  logic [LANES-1:0] keys,
  output logic [1:0]       score_code,
  output logic [LANES-1:0] hit_lane,
  output logic             overflow
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  logic [LANES-1:0] slot_valid;
  logic [1:0]       slot_code [LANES];
  logic [LANES-1:0] drop;
  logic [LANES-1:0] grant;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic             gap;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_judge #(
      .PERF_LEN (PERF_LEN),
      .GOOD_LEN (GOOD_LEN),
      .CNT_W    (CNT_W),
      .PENALIZE (PENALIZE)
    ) u_lane (
      .Clock      (Clock),
      .reset      (reset),
      .arrow_in   (arrow_in[g]),
      .key        (keys[g]),
      .grant      (grant[g]),
      .slot_valid (slot_valid[g]),
      .slot_code  (slot_code[g]),
      .drop       (drop[g])
    );
  end

  // Round-robin search for the first valid slot starting at rr_ptr.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    grant = '0;
    for (int off = 0; off < LANES; off++) begin
      idx = PTR_W'((int'(rr_ptr) + off) % LANES);
      if (!found && slot_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found && !gap) begin
      grant[gidx] = 1'b1;
    end
  end

  // Output registers, gap pacing, pointer advance and sticky overflow.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      score_code <= SC_NONE;
      hit_lane   <= '0;
      overflow   <= 1'b0;
      rr_ptr     <= '0;
      gap        <= 1'b0;
    end else begin
      overflow <= overflow | (|drop);
      if (gap) begin
        score_code <= SC_NONE;
        hit_lane   <= '0;
        gap        <= 1'b0;
      end else if (found) begin
        score_code <= slot_code[gidx];
        hit_lane   <= grant;
        gap        <= 1'b1;
        rr_ptr     <= (gidx == LAST_LANE) ? '0 : gidx + 1'b1;
      end else begin
        score_code <= SC_NONE;
        hit_lane   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arrow_judge.sv
// Directed bench for arrow_judge: a penalizing instance and a non-penalizing
// instance share the same stimulus; inputs change and outputs are sampled
// on the falling clock edge.
module tb_arrow_judge;

  logic       Clock;
  logic       reset;
  logic [3:0] arrow_in;
  logic [3:0] keys;
  logic [1:0] score_code, score_code_np;
  logic [3:0] hit_lane, hit_lane_np;
  logic       overflow, overflow_np;

  int checks;
  int errors;

  arrow_judge #(
    .LANES(4), .PERF_LEN(4), .GOOD_LEN(8), .CNT_W(4), .PENALIZE(1)
  ) dut (
    .Clock      (Clock),
    .reset      (reset),
    .arrow_in   (arrow_in),
    .keys       (keys),
    .score_code (score_code),
    .hit_lane   (hit_lane),
    .overflow   (overflow)
  );

  arrow_judge #(
    .LANES(4), .PERF_LEN(4), .GOOD_LEN(8), .CNT_W(4), .PENALIZE(0)
  ) dut_np (
    .Clock      (Clock),
    .reset      (reset),
    .arrow_in   (arrow_in),
    .keys       (keys),
    .score_code (score_code_np),
    .hit_lane   (hit_lane_np),
    .overflow   (overflow_np)
  );

  // Clock and watchdog
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; returns on the following falling edge.
  task automatic step();
    @(negedge Clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; arrow_in = '0; keys = '0;
    idle(2);
    checks++;
    if ({score_code, hit_lane, overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_hold: got code=%b hit=%b ovf=%b want 00/0000/0", score_code, hit_lane, overflow);
    end
    reset = 1'b0;
    idle(2);
    checks++;
    if ({score_code, hit_lane, overflow} !== 7'b0 || {score_code_np, hit_lane_np, overflow_np} !== 7'b0) begin
      errors++;
      $display("FAIL reset_release: got code=%b hit=%b ovf=%b np=%b/%b want all zero", score_code, hit_lane, overflow, score_code_np, hit_lane_np);
    end
  endtask

  task automatic test_perfect();
    arrow_in = 4'b0001; step();
    arrow_in = 4'b0000; step();
    keys = 4'b0001; step();
    checks++;
    if (score_code !== 2'b00) begin
      errors++;
      $display("FAIL perfect_latency: got code=%b want 00", score_code);
    end
    step();
    checks++;
    if (score_code !== 2'b10 || hit_lane !== 4'b0001) begin
      errors++;
      $display("FAIL perfect_hit: got code=%b hit=%b want 10/0001", score_code, hit_lane);
    end
    step();
    checks++;
    if (score_code !== 2'b00 || hit_lane !== 4'b0000) begin
      errors++;
      $display("FAIL perfect_gap: got code=%b hit=%b want 00/0000", score_code, hit_lane);
    end
    keys = 4'b0000; idle(2);
  endtask

  task automatic test_good();
    arrow_in = 4'b0001; step();
    arrow_in = 4'b0000; idle(6);
    keys = 4'b0001; step();
    step();
    checks++;
    if (score_code !== 2'b01 || hit_lane !== 4'b0001) begin
      errors++;
      $display("FAIL good_hit: got code=%b hit=%b want 01/0001", score_code, hit_lane);
    end
    step();
    checks++;
    if (score_code !== 2'b00) begin
      errors++;
      $display("FAIL good_gap: got code=%b want 00", score_code);
    end
    keys = 4'b0000; idle(2);
  endtask

  task automatic test_miss();
    arrow_in = 4'b0010; step();
    arrow_in = 4'b0000; idle(11);
    step();
    checks++;
    if (score_code !== 2'b00) begin
      errors++;
      $display("FAIL miss_early: got code=%b want 00", score_code);
    end
    step();
    checks++;
    if (score_code !== 2'b11 || hit_lane !== 4'b0010) begin
      errors++;
      $display("FAIL miss_code: got code=%b hit=%b want 11/0010", score_code, hit_lane);
    end
    step();
    checks++;
    if (score_code !== 2'b00 || hit_lane !== 4'b0000) begin
      errors++;
      $display("FAIL miss_gap: got code=%b hit=%b want 00/0000", score_code, hit_lane);
    end
  endtask

  task automatic test_stray();
    keys = 4'b1000; step();
    step();
    checks++;
    if (score_code !== 2'b11 || hit_lane !== 4'b1000) begin
      errors++;
      $display("FAIL stray_penalize: got code=%b hit=%b want 11/1000", score_code, hit_lane);
    end
    checks++;
    if (score_code_np !== 2'b00 || hit_lane_np !== 4'b0000) begin
      errors++;
      $display("FAIL stray_ignore: got code=%b hit=%b want 00/0000", score_code_np, hit_lane_np);
    end
    step();
    checks++;
    if (score_code_np !== 2'b00 || score_code !== 2'b00) begin
      errors++;
      $display("FAIL stray_after: got code=%b np=%b want 00/00", score_code, score_code_np);
    end
    keys = 4'b0000; idle(2);
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_hit;
    arrow_in = 4'b1111; step();
    arrow_in = 4'b0000; keys = 4'b1111; step();
    for (int i = 0; i < 4; i++) begin
      exp_hit = 4'b0001 << i;
      step();
      checks++;
      if (score_code !== 2'b10 || hit_lane !== exp_hit) begin
        errors++;
        $display("FAIL simul_grant%0d: got code=%b hit=%b want 10/%b", i, score_code, hit_lane, exp_hit);
      end
      step();
      checks++;
      if (score_code !== 2'b00 || hit_lane !== 4'b0000) begin
        errors++;
        $display("FAIL simul_gap%0d: got code=%b hit=%b want 00/0000", i, score_code, hit_lane);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL simul_overflow: got %b want 0", overflow);
    end
    keys = 4'b0000; idle(3);
  endtask

  task automatic test_back_to_back();
    arrow_in = 4'b0001; keys = 4'b0000; step();
    arrow_in = 4'b0001; keys = 4'b0001; step();
    arrow_in = 4'b0001; keys = 4'b0001; step();
    checks++;
    if (score_code !== 2'b10 || hit_lane !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_first: got code=%b hit=%b want 10/0001", score_code, hit_lane);
    end
    arrow_in = 4'b0000; keys = 4'b0000; step();
    checks++;
    if (score_code !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got code=%b want 00", score_code);
    end
    step();
    checks++;
    if (score_code !== 2'b11 || hit_lane !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_second: got code=%b hit=%b want 11/0001", score_code, hit_lane);
    end
    keys = 4'b0001; step();
    step();
    checks++;
    if (score_code !== 2'b10 || hit_lane !== 4'b0001 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_close: got code=%b hit=%b ovf=%b want 10/0001/0", score_code, hit_lane, overflow);
    end
    keys = 4'b0000; idle(3);
  endtask

  task automatic test_overflow();
    keys = 4'b0110; step();
    keys = 4'b0000; step();
    checks++;
    if (score_code !== 2'b11 || hit_lane !== 4'b0010 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first: got code=%b hit=%b ovf=%b want 11/0010/0", score_code, hit_lane, overflow);
    end
    keys = 4'b0100; step();
    checks++;
    if (score_code !== 2'b00 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got code=%b ovf=%b want 00/1", score_code, overflow);
    end
    step();
    checks++;
    if (score_code !== 2'b11 || hit_lane !== 4'b0100) begin
      errors++;
      $display("FAIL ovf_kept: got code=%b hit=%b want 11/0100", score_code, hit_lane);
    end
    keys = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (score_code !== 2'b00 || overflow !== 1'b1) begin
        errors++;
        $display("FAIL ovf_sticky%0d: got code=%b ovf=%b want 00/1", i, score_code, overflow);
      end
    end
  endtask

  task automatic test_reset_mid();
    arrow_in = 4'b0001; step();
    arrow_in = 4'b0000; idle(5);
    keys = 4'b0001; reset = 1'b1;
    #1;
    checks++;
    if ({score_code, hit_lane, overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async: got code=%b hit=%b ovf=%b want 00/0000/0", score_code, hit_lane, overflow);
    end
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (score_code !== 2'b00 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL reset_quiet%0d: got code=%b ovf=%b want 00/0", i, score_code, overflow);
      end
    end
    keys = 4'b0000; idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; arrow_in = '0; keys = '0;
    @(negedge Clock);
    test_reset();
    test_perfect();
    test_good();
    test_miss();
    test_stray();
    test_simultaneous();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
